// File: rtl/approx_adder_err_monitor.sv
// Streaming error-statistics engine: compares NUM_CH approximate adder results against
// the exact sum and accumulates per-channel error count, SAED and max error distance.
module approx_adder_err_monitor #(
  parameter int N       = 8,
  parameter int NUM_CH  = 3,
  parameter int SAMPLES = 256,
  localparam int CW     = $clog2(SAMPLES + 1),
  localparam int RW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int SW     = N + 1 + CW,
  localparam int EW     = N + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_a,
  input  logic [N-1:0]         in_b,
  input  logic [NUM_CH*EW-1:0] in_approx,
  output logic                 busy,
  output logic                 done,
  input  logic [RW-1:0]        rd_ch,
  output logic [CW-1:0]        rd_err_cnt,
  output logic [SW-1:0]        rd_saed,
  output logic [EW-1:0]        rd_max_ed
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            clr;
  logic            vld_p0, vld_p1, vld_p2;
  logic            last_acc;

  logic [EW-1:0]   exact_p1;
  logic [EW-1:0]   approx_p1 [NUM_CH];
  logic [EW-1:0]   ed_p2     [NUM_CH];
  logic [NUM_CH-1:0] nz_p2;

  logic [CW-1:0]   err_cnt_q [NUM_CH];
  logic [CW-1:0]   err_cnt_d [NUM_CH];
  logic [SW-1:0]   saed_q    [NUM_CH];
  logic [SW-1:0]   saed_d    [NUM_CH];
  logic [EW-1:0]   max_q     [NUM_CH];
  logic [EW-1:0]   max_d     [NUM_CH];

  // Unsigned distance between two EW-bit values, via a one-bit-wider signed difference.
  function automatic logic [EW-1:0] abs_dist(input logic [EW-1:0] x, input logic [EW-1:0] y);
    logic signed [EW:0] d;
    d = $signed({1'b0, x}) - $signed({1'b0, y});
    if (d < 0) d = -d;
    return d[EW-1:0];
  endfunction

  assign in_ready = (state_q == RUN);
  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign vld_p0   = in_valid && in_ready;
  assign last_acc = vld_p0 && (cnt_q == CW'(SAMPLES - 1));

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  if (start) begin state_d = RUN; clr = 1'b1; end
      RUN:   if (last_acc) state_d = DRAIN;
      DRAIN: if (!vld_p1 && !vld_p2) state_d = DONE;
      DONE:  if (start) begin state_d = RUN; clr = 1'b1; end
      default: state_d = IDLE;
    endcase
    if (clr) cnt_d = '0;
    else if (vld_p0) cnt_d = cnt_q + CW'(1);
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      err_cnt_d[k] = err_cnt_q[k];
      saed_d[k]    = saed_q[k];
      max_d[k]     = max_q[k];
      if (clr) begin
        err_cnt_d[k] = '0;
        saed_d[k]    = '0;
        max_d[k]     = '0;
      end else if (vld_p2) begin
        err_cnt_d[k] = err_cnt_q[k] + CW'(nz_p2[k]);
        saed_d[k]    = saed_q[k] + SW'(ed_p2[k]);
        max_d[k]     = (ed_p2[k] > max_q[k]) ? ed_p2[k] : max_q[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        err_cnt_q[k] <= '0;
        saed_q[k]    <= '0;
        max_q[k]     <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_p1  <= vld_p0;
      vld_p2  <= vld_p1;
      for (int k = 0; k < NUM_CH; k++) begin
        err_cnt_q[k] <= err_cnt_d[k];
        saed_q[k]    <= saed_d[k];
        max_q[k]     <= max_d[k];
      end
    end
  end

  // Stage 1: exact sum with carry; stage 2: per-channel distance and nonzero flag
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      exact_p1 <= {1'b0, in_a} + {1'b0, in_b};
      for (int k = 0; k < NUM_CH; k++) approx_p1[k] <= in_approx[k*EW +: EW];
    end
    if (vld_p1) begin
      for (int k = 0; k < NUM_CH; k++) begin
        ed_p2[k] <= abs_dist(exact_p1, approx_p1[k]);
        nz_p2[k] <= (exact_p1 != approx_p1[k]);
      end
    end
  end

  always_comb begin
    rd_err_cnt = '0;
    rd_saed    = '0;
    rd_max_ed  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_ch == RW'(k)) begin
        rd_err_cnt = err_cnt_q[k];
        rd_saed    = saed_q[k];
        rd_max_ed  = max_q[k];
      end
    end
  end

endmodule
